// File: rtl/paddle_pkg.sv
// Shared types and saturating helpers for the paddle timer array.
package paddle_pkg;

  localparam int POS_W_DEF = 9;

  typedef logic [POS_W_DEF-1:0] pos_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Subtract that floors at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    if (a > b) begin
      return a - b;
    end else begin
      return 32'd0;
    end
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end else begin
      return sum[31:0];
    end
  endfunction

  // Stick offset is relative to the centre position; result clamped to [0, max].
  function automatic logic [31:0] clamp_analog(input int init, input logic signed [7:0] a,
                                               input int max);
    int s;
    s = init + int'(a);
    if (s < 0) begin
      return 32'd0;
    end else if (s > max) begin
      return 32'(max);
    end else begin
      return 32'(s);
    end
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: position, per-frame line countdown and hold-to-accelerate tracking.
// PADDLE_ANALOG_EN adds the absolute stick position mode.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int POS_W        = 9,
  parameter int POS_MAX      = 255,
  parameter int POS_INIT     = 128,
  parameter int STEP_SLOW    = 5,
  parameter int STEP_FAST    = 8,
  parameter int ACCEL_FRAMES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vs_rise,
  input  logic             i_hs_rise,
  input  logic             i_speed_sel,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
`ifdef PADDLE_ANALOG_EN
  input  logic             i_analog_sel,
  input  logic [7:0]       i_analog_in,
`endif
  output logic             o_pad,
  output logic [POS_W-1:0] o_pos
);

  localparam int HOLD_W = (ACCEL_FRAMES < 1) ? 1 : $clog2(ACCEL_FRAMES + 1);

  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  r_count;
  logic [HOLD_W-1:0] r_hold;
  dir_e              r_dir;

  dir_e              w_dir;
  logic [31:0]       w_base;
  logic [31:0]       w_step;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  dir_e              w_dir_nxt;

  // Next position and hold state, applied only at the frame edge.
  always_comb begin
    w_pos_nxt  = r_pos;
    w_hold_nxt = r_hold;
    w_dir_nxt  = r_dir;
    w_dir      = i_btn_up ? DIR_UP : (i_btn_down ? DIR_DOWN : DIR_NONE);
    w_base     = i_speed_sel ? 32'(STEP_FAST) : 32'(STEP_SLOW);
    // Acceleration only counts while the same direction stays held.
    if ((w_dir == r_dir) && (r_hold == HOLD_W'(ACCEL_FRAMES))) begin
      w_step = w_base << 1;
    end else begin
      w_step = w_base;
    end
    case (w_dir)
      DIR_UP:   w_pos_nxt = POS_W'(sat_sub(32'(r_pos), w_step));
      DIR_DOWN: w_pos_nxt = POS_W'(sat_add(32'(r_pos), w_step, 32'(POS_MAX)));
      default:  w_pos_nxt = r_pos;
    endcase
    if (w_dir == DIR_NONE) begin
      w_hold_nxt = {HOLD_W{1'b0}};
    end else if (w_dir != r_dir) begin
      w_hold_nxt = HOLD_W'(1);
    end else if (r_hold == HOLD_W'(ACCEL_FRAMES)) begin
      w_hold_nxt = r_hold;
    end else begin
      w_hold_nxt = r_hold + HOLD_W'(1);
    end
    w_dir_nxt = w_dir;
`ifdef PADDLE_ANALOG_EN
    if (i_analog_sel) begin
      w_pos_nxt  = POS_W'(clamp_analog(POS_INIT, $signed(i_analog_in), POS_MAX));
      w_hold_nxt = {HOLD_W{1'b0}};
      w_dir_nxt  = DIR_NONE;
    end else begin
      w_dir_nxt = w_dir;
    end
`endif
  end

  // Frame reload has priority over the per-line countdown.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos   <= POS_W'(POS_INIT);
      r_count <= {POS_W{1'b0}};
      r_hold  <= {HOLD_W{1'b0}};
      r_dir   <= DIR_NONE;
    end else if (i_vs_rise) begin
      r_count <= r_pos;
      r_pos   <= w_pos_nxt;
      r_hold  <= w_hold_nxt;
      r_dir   <= w_dir_nxt;
    end else if (i_hs_rise && (r_count != {POS_W{1'b0}})) begin
      r_count <= r_count - POS_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_pad = (r_count == {POS_W{1'b0}});
  assign o_pos = r_pos;

endmodule

// File: rtl/paddle_timer_array.sv
// N-channel paddle RC-timing emulator with shared sync edge detection.
// Optional analog stick mode is enabled by defining PADDLE_ANALOG_EN.
module paddle_timer_array
  import paddle_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int POS_W        = 9,
  parameter int POS_MAX      = 255,
  parameter int POS_INIT     = 128,
  parameter int STEP_SLOW    = 5,
  parameter int STEP_FAST    = 8,
  parameter int ACCEL_FRAMES = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      hs,
  input  logic                      vs,
  input  logic                      speed_sel,
  input  logic [CHANNELS-1:0]       btn_up,
  input  logic [CHANNELS-1:0]       btn_down,
  input  logic [8*CHANNELS-1:0]     analog_in,
  input  logic [CHANNELS-1:0]       analog_sel,
  output logic [CHANNELS-1:0]       pad_out,
  output logic [POS_W*CHANNELS-1:0] pos_out
);

  logic r_hs_d;
  logic r_vs_d;
  logic w_hs_rise;
  logic w_vs_rise;

  // Sync delay registers for rising-edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs_d <= hs;
      r_vs_d <= vs;
    end
  end

  assign w_vs_rise = vs & ~r_vs_d;
  assign w_hs_rise = hs & ~r_hs_d;

`ifndef PADDLE_ANALOG_EN
  logic w_unused_analog;
  assign w_unused_analog = ^{analog_in, analog_sel};
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    paddle_channel #(
      .POS_W        (POS_W),
      .POS_MAX      (POS_MAX),
      .POS_INIT     (POS_INIT),
      .STEP_SLOW    (STEP_SLOW),
      .STEP_FAST    (STEP_FAST),
      .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_ch (
      .i_clk        (clk_sys),
      .i_reset      (reset),
      .i_vs_rise    (w_vs_rise),
      .i_hs_rise    (w_hs_rise),
      .i_speed_sel  (speed_sel),
      .i_btn_up     (btn_up[g]),
      .i_btn_down   (btn_down[g]),
`ifdef PADDLE_ANALOG_EN
      .i_analog_sel (analog_sel[g]),
      .i_analog_in  (analog_in[g*8 +: 8]),
`endif
      .o_pad        (pad_out[g]),
      .o_pos        (pos_out[g*POS_W +: POS_W])
    );
  end

endmodule
